// File: rtl/commit_perf_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : commit_perf_monitor_if
// Purpose  : Retire/commit bus observed by the commit performance monitor.
//            One strobe, sequence number and instruction word per lane.
// Ports    : valid [CHANNELS]      per-lane commit strobe
//            order [CHANNELS][64]  per-lane commit sequence number
//            inst  [CHANNELS][32]  per-lane committed instruction word
// Modports : master (drives the bus), slave (observes the bus)
// Revision : 1.0 - initial release
// ============================================================================
interface commit_perf_monitor_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]        valid;
  logic [CHANNELS-1:0][63:0]  order;
  logic [CHANNELS-1:0][31:0]  inst;

  modport master (output valid, output order, output inst);
  modport slave  (input  valid, input  order, input  inst);
endinterface
`default_nettype wire

// File: rtl/commit_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : commit_perf_monitor
// Purpose  : Counts cycles and committed instructions over the whole run or
//            over a marker-delimited segment, detects halt, and flags commit
//            ordering, lane packing, watchdog and post-halt errors.
// Ports    : clk        in   sole clock, rising edge
//            rst_n      in   synchronous active-low reset
//            bus        in   commit bus (slave modport)
//            halt       out  sticky, halt instruction committed
//            seg_active out  in SEGMENT state
//            seg_done   out  in DONE state
//            cycle_cnt  out  cycles in current window (saturating)
//            inst_cnt   out  commits in current window (saturating)
//            errcode    out  sticky: [0] order, [1] packing, [2] watchdog,
//                            [3] commit after halt
//            error      out  OR of errcode
// Revision : 1.0 - initial release
// ============================================================================
module commit_perf_monitor #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 64,
  parameter int WDOG_CYCLES = 10000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  commit_perf_monitor_if.slave  bus,
  output logic                  halt,
  output logic                  seg_active,
  output logic                  seg_done,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      inst_cnt,
  output logic [3:0]            errcode,
  output logic                  error
);

  typedef enum logic [1:0] {
    S_TOTAL   = 2'd0,
    S_SEGMENT = 2'd1,
    S_DONE    = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  localparam logic [31:0]      c_INST_HALT_A = 32'h0000_0063;
  localparam logic [31:0]      c_INST_HALT_B = 32'h0000_006F;
  localparam logic [31:0]      c_INST_HALT_C = 32'hF000_2013;
  localparam logic [31:0]      c_INST_START  = 32'h0010_2013;
  localparam logic [31:0]      c_INST_STOP   = 32'h0020_2013;
  localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [31:0]      c_IDLE_MAX    = 32'hFFFF_FFFF;
  localparam logic [31:0]      c_WDOG        = 32'(WDOG_CYCLES);

  state_t      r_state;
  logic [63:0] r_exp_order;
  logic [31:0] r_idle;

  function automatic logic is_halt(input logic [31:0] ins);
    return (ins == c_INST_HALT_A) || (ins == c_INST_HALT_B) || (ins == c_INST_HALT_C);
  endfunction

  logic [CHANNELS-1:0] w_eff;
  logic                w_halt_hit;
  logic [3:0]          w_eff_cnt;
  logic                w_order_err;
  logic                w_pack_err;
  logic                w_any_valid;
  logic                w_wdog_hit;
  logic [CHANNELS-1:0] w_valid_p1;
  state_t              w_mode;
  state_t              w_state_next;
  logic                w_zero;
  logic                w_tick;
  logic [3:0]          w_lanes;
  logic [CNT_W-1:0]    w_cyc_base;
  logic [CNT_W-1:0]    w_inst_base;
  logic [CNT_W:0]      w_cyc_sum;
  logic [CNT_W+3:0]    w_inst_sum;
  logic [CNT_W-1:0]    w_cyc_next;
  logic [CNT_W-1:0]    w_inst_next;
  logic [31:0]         w_idle_next;
  logic [63:0]         w_exp_next;
  logic [3:0]          w_err_next;
  logic                w_halt_next;

  // Effective lanes: valid lanes in index order, stopping after the first
  // halt. Each effective lane i must carry expected_order + i.
  always_comb begin
    w_eff       = '0;
    w_halt_hit  = 1'b0;
    w_eff_cnt   = '0;
    w_order_err = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.valid[i] && !w_halt_hit) begin
        w_eff[i]  = 1'b1;
        w_eff_cnt = w_eff_cnt + 4'd1;
        if (bus.order[i] != r_exp_order + 64'(i)) begin
          w_order_err = 1'b1;
        end
        if (is_halt(bus.inst[i])) begin
          w_halt_hit = 1'b1;
        end
      end
    end
  end

  // Walk effective lanes in order, applying markers as they appear.
  // w_zero: a start marker rebased the window; w_lanes: commits counted
  // since the last rebase; w_tick: this cycle adds to cycle_cnt.
  always_comb begin
    w_mode  = r_state;
    w_zero  = 1'b0;
    w_tick  = (r_state == S_TOTAL) || (r_state == S_SEGMENT);
    w_lanes = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_eff[i]) begin
        if (bus.inst[i] == c_INST_START) begin
          w_mode  = S_SEGMENT;
          w_zero  = 1'b1;
          w_lanes = '0;
          w_tick  = 1'b0;
        end else if ((w_mode == S_TOTAL) || (w_mode == S_SEGMENT)) begin
          w_lanes = w_lanes + 4'd1;
          if (bus.inst[i] == c_INST_STOP) begin
            // Stop closes the window including this cycle, even when a
            // start earlier in the same cycle had cleared the tick.
            w_mode = S_DONE;
            w_tick = 1'b1;
          end
        end
      end
    end
    w_cyc_base  = w_zero ? '0 : cycle_cnt;
    w_inst_base = w_zero ? '0 : inst_cnt;
    w_cyc_sum   = {1'b0, w_cyc_base} + {{CNT_W{1'b0}}, w_tick};
    w_cyc_next  = w_cyc_sum[CNT_W] ? c_CNT_MAX : w_cyc_sum[CNT_W-1:0];
    w_inst_sum  = {4'b0000, w_inst_base} + {{CNT_W{1'b0}}, w_lanes};
    w_inst_next = (|w_inst_sum[CNT_W+3:CNT_W]) ? c_CNT_MAX : w_inst_sum[CNT_W-1:0];
  end

  always_comb begin
    w_any_valid = |bus.valid;
    // A run starting at lane 0 has the form 0..01..1; adding one then
    // shares no set bit with the original pattern.
    w_valid_p1  = bus.valid + CHANNELS'(1);
    w_pack_err  = |(w_valid_p1 & bus.valid);
    w_idle_next = w_any_valid ? '0 :
                  ((r_idle == c_IDLE_MAX) ? r_idle : r_idle + 32'd1);
    w_wdog_hit  = (WDOG_CYCLES != 0) && (r_state != S_HALTED) && (w_idle_next >= c_WDOG);

    w_err_next   = errcode;
    w_halt_next  = halt;
    w_state_next = r_state;
    w_exp_next   = r_exp_order;
    if (r_state == S_HALTED) begin
      // Commits after halt are only flagged, never checked or counted.
      if (w_any_valid) begin
        w_err_next[3] = 1'b1;
      end
    end else begin
      w_err_next[0] = errcode[0] | w_order_err;
      w_err_next[1] = errcode[1] | w_pack_err;
      w_exp_next    = r_exp_order + 64'(w_eff_cnt);
      if (w_halt_hit) begin
        w_state_next = S_HALTED;
        w_halt_next  = 1'b1;
      end else begin
        w_state_next = w_mode;
      end
    end
    if (w_wdog_hit) begin
      w_err_next[2] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_TOTAL;
      r_exp_order <= '0;
      r_idle      <= '0;
      halt        <= 1'b0;
      seg_active  <= 1'b0;
      seg_done    <= 1'b0;
      cycle_cnt   <= '0;
      inst_cnt    <= '0;
      errcode     <= '0;
      error       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_exp_order <= w_exp_next;
      r_idle      <= w_idle_next;
      halt        <= w_halt_next;
      seg_active  <= (w_state_next == S_SEGMENT);
      seg_done    <= (w_state_next == S_DONE);
      if (r_state != S_HALTED) begin
        cycle_cnt <= w_cyc_next;
        inst_cnt  <= w_inst_next;
      end
      errcode     <= w_err_next;
      error       <= |w_err_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_commit_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_perf_monitor
// Purpose  : Self-checking bench for commit_perf_monitor. Instance A
//            (2 lanes, 64-bit counters, watchdog 8) runs a hand-derived
//            vector table then random traffic; instance B (4 lanes, 6-bit
//            counters, watchdog off) runs random traffic throughout and a
//            saturation sequence. Random traffic is checked against a
//            lane-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_perf_monitor;

  localparam logic [31:0] c_NOP    = 32'h0000_0013;
  localparam logic [31:0] c_START  = 32'h0010_2013;
  localparam logic [31:0] c_STOP   = 32'h0020_2013;
  localparam logic [31:0] c_HALT_J = 32'h0000_006F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b;
  logic halt_a, act_a, done_a, error_a;
  logic [63:0] cyc_a, ins_a;
  logic [3:0]  err_a;
  logic halt_b, act_b, done_b, error_b;
  logic [5:0]  cyc_b, ins_b;
  logic [3:0]  err_b;

  commit_perf_monitor_if #(.CHANNELS(2)) bus_a ();
  commit_perf_monitor_if #(.CHANNELS(4)) bus_b ();

  commit_perf_monitor #(.CHANNELS(2), .CNT_W(64), .WDOG_CYCLES(8)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a), .halt(halt_a), .seg_active(act_a),
    .seg_done(done_a), .cycle_cnt(cyc_a), .inst_cnt(ins_a), .errcode(err_a), .error(error_a)
  );

  commit_perf_monitor #(.CHANNELS(4), .CNT_W(6), .WDOG_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b), .halt(halt_b), .seg_active(act_b),
    .seg_done(done_b), .cycle_cnt(cyc_b), .inst_cnt(ins_b), .errcode(err_b), .error(error_b)
  );

  int nvec;
  int nfail;

  // ---------------- reference model ----------------
  // st: 0 TOTAL, 1 SEGMENT, 2 DONE, 3 HALTED
  typedef struct {
    int          st;
    bit          halt;
    logic [63:0] cyc;
    logic [63:0] ins;
    logic [63:0] exp_ord;
    int unsigned idle;
    logic [3:0]  err;
  } mstate_t;

  mstate_t ma, mb;

  function automatic bit is_halt_insn(input logic [31:0] x);
    return (x == 32'h0000_0063) || (x == 32'h0000_006F) || (x == 32'hF000_2013);
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] x, input logic [63:0] a,
                                          input logic [63:0] mx);
    if (mx - x < a) return mx;
    return x + a;
  endfunction

  task automatic model_clear(inout mstate_t m);
    m.st = 0; m.halt = 0; m.cyc = '0; m.ins = '0; m.exp_ord = '0; m.idle = 0; m.err = '0;
  endtask

  task automatic model_step(inout mstate_t m, input int ch, input int w, input int wdog,
                            input bit rn, input logic [7:0] v,
                            input logic [511:0] ord, input logic [255:0] ins);
    logic [63:0] mx;
    int          eff[$];
    bit          tick;
    logic [31:0] x;
    if (!rn) begin
      model_clear(m);
      return;
    end
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (v != 0) m.idle = 0;
    else m.idle++;
    if (wdog != 0 && m.st != 3 && m.idle >= wdog) m.err[2] = 1'b1;
    if (m.st == 3) begin
      if (v != 0) m.err[3] = 1'b1;
      return;
    end
    for (int i = 1; i < ch; i++)
      if (v[i] && !v[i-1]) m.err[1] = 1'b1;
    for (int i = 0; i < ch; i++) begin
      if (v[i]) begin
        eff.push_back(i);
        if (is_halt_insn(ins[i*32 +: 32])) break;
      end
    end
    foreach (eff[k])
      if (ord[eff[k]*64 +: 64] != m.exp_ord + 64'(eff[k])) m.err[0] = 1'b1;
    m.exp_ord = m.exp_ord + 64'(eff.size());
    tick = (m.st == 0) || (m.st == 1);
    foreach (eff[k]) begin
      x = ins[eff[k]*32 +: 32];
      if (x == c_START) begin
        m.st = 1; m.cyc = '0; m.ins = '0; tick = 0;
      end else if (m.st == 0 || m.st == 1) begin
        m.ins = sat_add(m.ins, 64'd1, mx);
        if (x == c_STOP) begin
          m.cyc = sat_add(m.cyc, 64'd1, mx);
          m.st  = 2;
          tick  = 0;
        end
      end
    end
    if (tick) m.cyc = sat_add(m.cyc, 64'd1, mx);
    if (eff.size() > 0 && is_halt_insn(ins[eff[eff.size()-1]*32 +: 32])) begin
      m.st = 3; m.halt = 1'b1;
    end
  endtask

  // ---------------- comparison ----------------
  task automatic cmp(input string name,
                     input bit ah, input bit aa, input bit ad, input logic [63:0] ac,
                     input logic [63:0] ai, input logic [3:0] ae, input bit aerr,
                     input bit eh, input bit ea, input bit ed, input logic [63:0] ec,
                     input logic [63:0] ei, input logic [3:0] ee);
    nvec++;
    if (ah !== eh || aa !== ea || ad !== ed || ac !== ec || ai !== ei ||
        ae !== ee || aerr !== (|ee)) begin
      nfail++;
      $display("FAIL %s: got halt=%0b act=%0b done=%0b cyc=%0d inst=%0d err=%b error=%0b; want halt=%0b act=%0b done=%0b cyc=%0d inst=%0d err=%b error=%0b",
               name, ah, aa, ad, ac, ai, ae, aerr, eh, ea, ed, ec, ei, ee, |ee);
    end
  endtask

  task automatic cmp_model_a(input string name);
    cmp(name, halt_a, act_a, done_a, cyc_a, ins_a, err_a, error_a,
        ma.halt, ma.st == 1, ma.st == 2, ma.cyc, ma.ins, ma.err);
  endtask

  task automatic cmp_model_b(input string name);
    cmp(name, halt_b, act_b, done_b, 64'(cyc_b), 64'(ins_b), err_b, error_b,
        mb.halt, mb.st == 1, mb.st == 2, mb.cyc, mb.ins, mb.err);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive_a(input bit rn, input logic [7:0] v, input logic [511:0] ord,
                         input logic [255:0] ins);
    rst_n_a = rn;
    bus_a.valid = v[1:0];
    for (int i = 0; i < 2; i++) begin
      bus_a.order[i] = ord[i*64 +: 64];
      bus_a.inst[i]  = ins[i*32 +: 32];
    end
  endtask

  task automatic drive_b(input bit rn, input logic [7:0] v, input logic [511:0] ord,
                         input logic [255:0] ins);
    rst_n_b = rn;
    bus_b.valid = v[3:0];
    for (int i = 0; i < 4; i++) begin
      bus_b.order[i] = ord[i*64 +: 64];
      bus_b.inst[i]  = ins[i*32 +: 32];
    end
  endtask

  task automatic gen_rand(input int ch, input logic [63:0] exp, inout int burst,
                          output bit rn, output logic [7:0] v,
                          output logic [511:0] ord, output logic [255:0] ins);
    int r;
    int n;
    logic [7:0] mask;
    mask = 8'((16'd1 << ch) - 16'd1);
    rn   = ($urandom_range(0, 79) != 0);
    v = '0; ord = '0; ins = '0;
    if (burst > 0) begin
      burst--;
    end else begin
      r = $urandom_range(0, 99);
      if (r < 3) burst = $urandom_range(5, 12);
      else if (r < 12) v = 8'($urandom) & mask;
      else begin
        n = $urandom_range(0, ch);
        v = 8'((16'd1 << n) - 16'd1);
      end
    end
    for (int i = 0; i < ch; i++) begin
      ord[i*64 +: 64] = exp + 64'(i) + (($urandom_range(0, 39) == 0) ? 64'd1 : 64'd0);
      r = $urandom_range(0, 99);
      ins[i*32 +: 32] = (r < 5)  ? c_START :
                        (r < 10) ? c_STOP :
                        (r < 11) ? 32'h0000_0063 :
                        (r < 12) ? 32'h0000_006F :
                        (r < 13) ? 32'hF000_2013 :
                        (r < 40) ? 32'($urandom) : c_NOP;
    end
  endtask

  // ---------------- directed table for instance A ----------------
  typedef struct {
    bit          rn;
    logic [1:0]  valid;
    logic [63:0] o0, o1;
    logic [31:0] i0, i1;
    bit          e_halt, e_act, e_done;
    logic [63:0] e_cyc, e_ins;
    logic [3:0]  e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rn, input logic [1:0] v, input int o0, input int o1,
                     input logic [31:0] i0, input logic [31:0] i1,
                     input bit h, input bit a, input bit d, input int c, input int n,
                     input logic [3:0] e);
    vec_t t;
    t.rn = rn; t.valid = v; t.o0 = 64'(o0); t.o1 = 64'(o1); t.i0 = i0; t.i1 = i1;
    t.e_halt = h; t.e_act = a; t.e_done = d; t.e_cyc = 64'(c); t.e_ins = 64'(n); t.e_err = e;
    tbl.push_back(t);
  endtask

  task automatic add_reset();
    add(0, 2'b00, 0, 0, c_NOP, c_NOP, 0, 0, 0, 0, 0, 4'b0000);
  endtask

  logic [7:0]   v_s;
  logic [511:0] ord_s;
  logic [255:0] ins_s;
  bit           rn_s;
  int           burst_a, burst_b;

  initial begin
    nvec = 0; nfail = 0; burst_a = 0; burst_b = 0;
    model_clear(ma);
    model_clear(mb);

    // Full-run counting: 10 cycles of two in-order commits.
    add_reset();
    for (int j = 1; j <= 10; j++)
      add(1, 2'b11, 2*(j-1), 2*(j-1)+1, c_NOP, c_NOP, 0, 0, 0, j, 2*j, 4'b0000);
    // Segment: start on lane 0, four full cycles, stop on lane 0, then frozen.
    add_reset();
    add(1, 2'b11, 0, 1, c_START, c_NOP, 0, 1, 0, 0, 1, 4'b0000);
    for (int j = 1; j <= 4; j++)
      add(1, 2'b11, 2*j, 2*j+1, c_NOP, c_NOP, 0, 1, 0, j, 1+2*j, 4'b0000);
    add(1, 2'b11, 10, 11, c_STOP, c_NOP, 0, 0, 1, 5, 10, 4'b0000);
    for (int j = 0; j < 2; j++)
      add(1, 2'b11, 12+2*j, 13+2*j, c_NOP, c_NOP, 0, 0, 1, 5, 10, 4'b0000);
    // Packing error then order gap; both bits stay set.
    add_reset();
    add(1, 2'b01, 0, 0, c_NOP, c_NOP, 0, 0, 0, 1, 1, 4'b0000);
    add(1, 2'b11, 1, 2, c_NOP, c_NOP, 0, 0, 0, 2, 3, 4'b0000);
    add(1, 2'b11, 3, 4, c_NOP, c_NOP, 0, 0, 0, 3, 5, 4'b0000);
    add(1, 2'b10, 0, 6, c_NOP, c_NOP, 0, 0, 0, 4, 6, 4'b0010);
    add(1, 2'b01, 7, 0, c_NOP, c_NOP, 0, 0, 0, 5, 7, 4'b0011);
    add(1, 2'b11, 7, 8, c_NOP, c_NOP, 0, 0, 0, 6, 9, 4'b0011);
    // Halt on lane 0 hides lane 1; a later commit flags commit-after-halt.
    add_reset();
    add(1, 2'b11, 0, 1, c_HALT_J, c_NOP, 1, 0, 0, 1, 1, 4'b0000);
    add(1, 2'b00, 0, 0, c_NOP, c_NOP, 1, 0, 0, 1, 1, 4'b0000);
    add(1, 2'b01, 1, 0, c_NOP, c_NOP, 1, 0, 0, 1, 1, 4'b1000);
    // Watchdog fires on the eighth idle cycle; reset clears everything.
    add_reset();
    for (int j = 1; j <= 7; j++)
      add(1, 2'b00, 0, 0, c_NOP, c_NOP, 0, 0, 0, j, 0, 4'b0000);
    add(1, 2'b00, 0, 0, c_NOP, c_NOP, 0, 0, 0, 8, 0, 4'b0100);
    add_reset();

    foreach (tbl[k]) begin
      ord_s = '0; ins_s = '0;
      ord_s[63:0] = tbl[k].o0; ord_s[127:64] = tbl[k].o1;
      ins_s[31:0] = tbl[k].i0; ins_s[63:32]  = tbl[k].i1;
      drive_a(tbl[k].rn, {6'b0, tbl[k].valid}, ord_s, ins_s);
      gen_rand(4, mb.exp_ord, burst_b, rn_s, v_s, ord_s, ins_s);
      if (k == 0) rn_s = 1'b0;
      drive_b(rn_s, v_s, ord_s, ins_s);
      @(posedge clk); #1;
      model_step(mb, 4, 6, 0, rn_s, v_s, ord_s, ins_s);
      cmp($sformatf("tbl_a[%0d]", k), halt_a, act_a, done_a, cyc_a, ins_a, err_a, error_a,
          tbl[k].e_halt, tbl[k].e_act, tbl[k].e_done, tbl[k].e_cyc, tbl[k].e_ins, tbl[k].e_err);
      cmp_model_b($sformatf("rand_b_t%0d", k));
    end

    // Random traffic on both instances against the model.
    for (int c = 0; c < 3000; c++) begin
      gen_rand(2, ma.exp_ord, burst_a, rn_s, v_s, ord_s, ins_s);
      if (c == 0) rn_s = 1'b0;
      drive_a(rn_s, v_s, ord_s, ins_s);
      @(negedge clk);
      model_step(ma, 2, 64, 8, rn_s, v_s, ord_s, ins_s);
      gen_rand(4, mb.exp_ord, burst_b, rn_s, v_s, ord_s, ins_s);
      drive_b(rn_s, v_s, ord_s, ins_s);
      model_step(mb, 4, 6, 0, rn_s, v_s, ord_s, ins_s);
      @(posedge clk); #1;
      cmp_model_a($sformatf("rand_a[%0d]", c));
      cmp_model_b($sformatf("rand_b[%0d]", c));
    end

    // Saturation on the 6-bit instance: 20 cycles x 4 commits caps at 63.
    for (int c = 0; c <= 20; c++) begin
      drive_a(1'b0, 8'd0, '0, '0);
      v_s = (c == 0) ? 8'h00 : 8'h0F;
      ord_s = '0; ins_s = '0;
      for (int i = 0; i < 4; i++) begin
        ord_s[i*64 +: 64] = mb.exp_ord + 64'(i);
        ins_s[i*32 +: 32] = c_NOP;
      end
      rn_s = (c != 0);
      drive_b(rn_s, v_s, ord_s, ins_s);
      @(posedge clk); #1;
      model_step(mb, 4, 6, 0, rn_s, v_s, ord_s, ins_s);
      cmp_model_b($sformatf("sat_b[%0d]", c));
    end
    cmp("sat_b_final", halt_b, act_b, done_b, 64'(cyc_b), 64'(ins_b), err_b, error_b,
        1'b0, 1'b0, 1'b0, 64'd20, 64'd63, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
